mux_n_pipe: RTL and testbench

//  Parametrised N-input, WIDTH-bit registered selector. Generalises the bit-level

---
 rtl/mux_n_pipe.sv | 92 +++++++++
 tb/tb_mux_n_pipe.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_n_pipe.sv
// N-channel WIDTH-bit selector into a 2-entry output buffer with valid/ready.
// Define MUX_SEL_CHECK_EN to add the sticky sel_err out-of-range flag.
module mux_n_pipe #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [SEL_W-1:0]   sel,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel,
  output logic               out_valid,
  input  logic               out_ready
`ifdef MUX_SEL_CHECK_EN
  ,
  output logic               sel_err
`endif
);

  logic [1:0]       count;
  logic [WIDTH-1:0] b_data;
  logic [SEL_W-1:0] b_sel;
  logic [WIDTH-1:0] sel_data;
  logic             sel_hit;
  logic             push;
  logic             pop;

  // in_ready is masked during reset: reset discards any word offered then.
  always_comb begin
    sel_data = '0;
    sel_hit  = 1'b0;
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      if (sel == SEL_W'(i)) begin
        sel_hit     = 1'b1;
        sel_data    = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = !rst && (count != 2'd2);
      end
    end
  end

  assign push      = |(in_valid & in_ready);
  assign out_valid = (count != 2'd0);
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= 2'd0;
      out_data <= '0;
      out_sel  <= '0;
      b_data   <= '0;
      b_sel    <= '0;
    end else begin
      if (pop && count == 2'd2) begin
        out_data <= b_data;
        out_sel  <= b_sel;
      end else if (push && (count == 2'd0 || pop)) begin
        out_data <= sel_data;
        out_sel  <= sel;
      end else if (push) begin
        b_data <= sel_data;
        b_sel  <= sel;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

`ifdef MUX_SEL_CHECK_EN
  logic sel_bad;
  assign sel_bad = !sel_hit && (|in_valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_err <= 1'b0;
    end else if (sel_bad) begin
      sel_err <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && sel_bad)
      $error("mux_n_pipe: sel %0d out of range with valid input", sel);
  end
`endif
`endif

endmodule

// File: tb/tb_mux_n_pipe.sv
// Bench for mux_n_pipe: directed table, random run against a queue model,
// and an N=3 instance for out-of-range select.
module tb_mux_n_pipe;

  logic        clk;
  logic        rst;
  logic [127:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [1:0]  sel;
  logic [31:0] out_data;
  logic [1:0]  out_sel;
  logic        out_valid;
  logic        out_ready;

  logic        rst3;
  logic [23:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic [1:0]  sel3;
  logic [7:0]  out_data3;
  logic [1:0]  out_sel3;
  logic        out_valid3;
  logic        out_ready3;
`ifdef MUX_SEL_CHECK_EN
  logic        sel_err;
  logic        sel_err3;
`endif

  int checks;
  int errors;

  mux_n_pipe #(.WIDTH(32), .N(4)) dut (
    .clk(clk), .rst(rst), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .sel(sel),
    .out_data(out_data), .out_sel(out_sel),
    .out_valid(out_valid), .out_ready(out_ready)
`ifdef MUX_SEL_CHECK_EN
    , .sel_err(sel_err)
`endif
  );

  mux_n_pipe #(.WIDTH(8), .N(3)) dut3 (
    .clk(clk), .rst(rst3), .in_data(in_data3),
    .in_valid(in_valid3), .in_ready(in_ready3), .sel(sel3),
    .out_data(out_data3), .out_sel(out_sel3),
    .out_valid(out_valid3), .out_ready(out_ready3)
`ifdef MUX_SEL_CHECK_EN
    , .sel_err(sel_err3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_words(input logic [31:0] d);
    for (int i = 0; i < 4; i++)
      in_data[i*32 +: 32] = d + 32'(i);
  endtask

  typedef struct {
    logic        rst;
    logic [1:0]  sel;
    logic [3:0]  iv;
    logic        ordy;
    logic [31:0] d;
    logic [3:0]  eir;
    logic        eov;
    logic [31:0] eod;
    logic [1:0]  eos;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  s;
  } ent_t;

  vec_t tv[17];
  ent_t q[$];
  logic [31:0] last_d;
  logic [1:0]  last_s;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; sel = 2'd0; in_valid = 4'hF; out_ready = 1'b0;
    in_data = '0;
    rst3 = 1'b1; sel3 = 2'd0; in_valid3 = '0; out_ready3 = 1'b1;
    in_data3 = '0;

    // rst sel iv ordy d | in_ready out_valid out_data out_sel
    tv[0]  = '{1, 0, 4'hF, 0, 32'h0,        4'h0, 0, 32'h0,        0};
    tv[1]  = '{0, 2, 4'h4, 1, 32'hDEADBEED, 4'h4, 0, 32'h0,        0};
    tv[2]  = '{0, 2, 4'h0, 1, 32'h0,        4'h4, 1, 32'hDEADBEEF, 2};
    tv[3]  = '{0, 0, 4'h1, 0, 32'hA0,       4'h1, 0, 32'hDEADBEEF, 2};
    tv[4]  = '{0, 0, 4'h1, 0, 32'hB0,       4'h1, 1, 32'hA0,       0};
    tv[5]  = '{0, 0, 4'h1, 0, 32'hC0,       4'h0, 1, 32'hA0,       0};
    tv[6]  = '{0, 0, 4'h1, 1, 32'hC0,       4'h0, 1, 32'hA0,       0};
    tv[7]  = '{0, 0, 4'h1, 1, 32'hC0,       4'h1, 1, 32'hB0,       0};
    tv[8]  = '{0, 0, 4'h0, 1, 32'h0,        4'h1, 1, 32'hC0,       0};
    tv[9]  = '{0, 0, 4'hF, 1, 32'h100,      4'h1, 0, 32'hC0,       0};
    tv[10] = '{0, 1, 4'hF, 1, 32'h200,      4'h2, 1, 32'h100,      0};
    tv[11] = '{0, 2, 4'hF, 1, 32'h300,      4'h4, 1, 32'h201,      1};
    tv[12] = '{0, 3, 4'hF, 1, 32'h400,      4'h8, 1, 32'h302,      2};
    tv[13] = '{0, 3, 4'h0, 0, 32'h0,        4'h8, 1, 32'h403,      3};
    tv[14] = '{0, 0, 4'h1, 0, 32'h500,      4'h1, 1, 32'h403,      3};
    tv[15] = '{1, 0, 4'h1, 1, 32'h600,      4'h0, 1, 32'h403,      3};
    tv[16] = '{0, 0, 4'h0, 1, 32'h0,        4'h1, 0, 32'h0,        0};

    @(posedge clk); #1;
    for (int k = 0; k < 17; k++) begin
      rst = tv[k].rst; sel = tv[k].sel; in_valid = tv[k].iv;
      out_ready = tv[k].ordy; set_words(tv[k].d);
      @(negedge clk);
      chk($sformatf("tv%0d in_ready", k), 64'(in_ready), 64'(tv[k].eir));
      chk($sformatf("tv%0d out_valid", k), 64'(out_valid), 64'(tv[k].eov));
      chk($sformatf("tv%0d out_data", k), 64'(out_data), 64'(tv[k].eod));
      chk($sformatf("tv%0d out_sel", k), 64'(out_sel), 64'(tv[k].eos));
      @(posedge clk); #1;
    end

    // Random run; buffer empty and head zero after the last table row.
    q.delete();
    last_d = '0;
    last_s = '0;
    for (int c = 0; c < 500; c++) begin
      logic do_pop;
      logic do_push;
      ent_t e;
      rst = ($urandom_range(0, 49) == 0);
      sel = 2'($urandom_range(0, 3));
      in_valid = 4'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = $urandom;
      @(negedge clk);
      chk("rnd in_ready", 64'(in_ready),
          (rst || q.size() == 2) ? 64'd0 : (64'd1 << sel));
      chk("rnd out_valid", 64'(out_valid), 64'(q.size() != 0));
      chk("rnd out_data", 64'(out_data),
          64'(q.size() != 0 ? q[0].d : last_d));
      chk("rnd out_sel", 64'(out_sel),
          64'(q.size() != 0 ? q[0].s : last_s));
      if (rst) begin
        q.delete();
        last_d = '0;
        last_s = '0;
      end else begin
        do_pop  = (q.size() != 0) && out_ready;
        do_push = in_valid[sel] && (q.size() < 2);
        e.d = in_data[sel*32 +: 32];
        e.s = sel;
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(e);
        if (q.size() != 0) begin
          last_d = q[0].d;
          last_s = q[0].s;
        end
      end
      @(posedge clk); #1;
    end

    // N=3 instance: out-of-range select never accepts.
    rst3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; in_data3 = 24'h332211;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("oor in_ready", 64'(in_ready3), 64'd0);
      chk("oor out_valid", 64'(out_valid3), 64'd0);
`ifdef MUX_SEL_CHECK_EN
      if (c > 0) chk("oor sel_err", 64'(sel_err3), 64'd1);
`endif
      @(posedge clk); #1;
    end
    sel3 = 2'd1; in_valid3 = 3'b010; in_data3 = 24'h115A33;
    @(negedge clk);
    chk("n3 in_ready", 64'(in_ready3), 64'h2);
    @(posedge clk); #1;
    in_valid3 = 3'b000;
    @(negedge clk);
    chk("n3 out_valid", 64'(out_valid3), 64'd1);
    chk("n3 out_data", 64'(out_data3), 64'h5A);
    chk("n3 out_sel", 64'(out_sel3), 64'd1);
`ifdef MUX_SEL_CHECK_EN
    chk("n3 sel_err sticky", 64'(sel_err3), 64'd1);
`endif
    @(posedge clk); #1;
    rst3 = 1'b1;
    @(posedge clk); #1;
    rst3 = 1'b0;
    @(negedge clk);
    chk("n3 rst out_valid", 64'(out_valid3), 64'd0);
`ifdef MUX_SEL_CHECK_EN
    chk("n3 rst sel_err", 64'(sel_err3), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
